// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared encodings and beat-address helper for the memory port arbiter
package mem_bus_pkg;
    typedef enum logic [1:0] {IDLE, XFER, DONE} state_e;
    typedef enum logic {OWN_I, OWN_D} owner_e;
    localparam int BEAT_BYTES = 4;
    function automatic logic [31:0] beat_addr(input logic [31:0] base, input logic [3:0] idx);
        return base + {26'd0, idx, 2'b00};
    endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: I-side, D-side and main-memory signals of the shared memory port
interface mem_port_arbiter_if;
    logic        i_req, i_gnt, i_beat, i_done;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_beat, d_done;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        err;
    logic        m_req, m_we, m_ack;
    logic [31:0] m_addr, m_wdata, m_rdata;
    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ack, m_rdata,
        output i_gnt, i_beat, i_done, i_rdata, d_gnt, d_beat, d_done, d_rdata, err,
               m_req, m_we, m_addr, m_wdata
    );
    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ack, m_rdata,
        input  i_gnt, i_beat, i_done, i_rdata, d_gnt, d_beat, d_done, d_rdata, err,
               m_req, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick; bit 0 is the I side, bit 1 the D side
module rr_arb2
    import mem_bus_pkg::*;
(
    input  logic [1:0] req_i,
    input  owner_e     last_i,
    output logic [1:0] gnt_o
);
    always_comb gnt_o = &req_i ? (last_i == OWN_D ? 2'b01 : 2'b10) : req_i;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between I refill and D refill/write-back,
// sequencing a fixed-length burst per grant with a per-beat ack timeout
module mem_port_arbiter
    import mem_bus_pkg::*;
#(
    parameter int BURST   = 4,
    parameter int TIMEOUT = 255
) (
    input logic clk,
    input logic rst,
    mem_port_arbiter_if.master bus
);
    localparam int CW = BURST > 1 ? $clog2(BURST) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [31:0] LINE_MASK = ~(32'(BURST * BEAT_BYTES) - 32'd1);

    state_e         state_q;
    owner_e         own_q, last_q;
    logic           we_q, gnt_q, done_q, err_q;
    logic [31:0]    base_q, i_rdata_q, d_rdata_q;
    logic [CW-1:0]  cnt_q;
    logic [TW-1:0]  tcnt_q;
    logic [1:0]     pick_d;
    logic           xfer, ack, last_beat, timeout;

    rr_arb2 u_arb (.req_i({bus.d_req, bus.i_req}), .last_i(last_q), .gnt_o(pick_d));

    assign xfer      = state_q == XFER;
    assign ack       = xfer & bus.m_ack;
    assign last_beat = cnt_q == CW'(BURST - 1);
    assign timeout   = xfer & ~bus.m_ack & (tcnt_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q   <= IDLE;
            own_q     <= OWN_I;
            last_q    <= OWN_I;
            we_q      <= 1'b0;
            gnt_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            base_q    <= '0;
            cnt_q     <= '0;
            tcnt_q    <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (|pick_d) begin
                    state_q <= XFER;
                    own_q   <= pick_d[1] ? OWN_D : OWN_I;
                    we_q    <= pick_d[1] & bus.d_we;
                    base_q  <= (pick_d[1] ? bus.d_addr : bus.i_addr) & LINE_MASK;
                    gnt_q   <= 1'b1;
                    cnt_q   <= '0;
                    tcnt_q  <= '0;
                end
                XFER: begin
                    if (bus.m_ack) begin
                        tcnt_q <= '0;
                        cnt_q  <= last_beat ? cnt_q : cnt_q + CW'(1);
                        if (own_q == OWN_D) d_rdata_q <= bus.m_rdata;
                        else i_rdata_q <= bus.m_rdata;
                    end else if (tcnt_q != '1) tcnt_q <= tcnt_q + TW'(1);
                    // a timed-out beat ends the burst early; the owner still sees done
                    if ((bus.m_ack && last_beat) || timeout) begin
                        state_q <= DONE;
                        gnt_q   <= 1'b0;
                        done_q  <= 1'b1;
                    end
                    if (timeout) err_q <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    cnt_q   <= '0;
                    last_q  <= own_q;
                end
                default: state_q <= IDLE;
            endcase
        end

    assign bus.i_gnt   = gnt_q & (own_q == OWN_I);
    assign bus.d_gnt   = gnt_q & (own_q == OWN_D);
    assign bus.i_done  = done_q & (own_q == OWN_I);
    assign bus.d_done  = done_q & (own_q == OWN_D);
    assign bus.i_beat  = ack & (own_q == OWN_I);
    assign bus.d_beat  = ack & (own_q == OWN_D);
    assign bus.i_rdata = bus.i_beat ? bus.m_rdata : i_rdata_q;
    assign bus.d_rdata = bus.d_beat ? bus.m_rdata : d_rdata_q;
    assign bus.err     = err_q;
    assign bus.m_req   = xfer;
    assign bus.m_we    = xfer & we_q;
    assign bus.m_addr  = xfer ? beat_addr(base_q, 4'(cnt_q)) : '0;
    assign bus.m_wdata = xfer ? bus.d_wdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bursts with a beat/done scoreboard checked by a negedge monitor
module tb_mem_port_arbiter;
    localparam logic [31:0] MAGIC = 32'hA5A5_0000;
    localparam logic [31:0] WBASE = 32'hCAFE_0000;

    typedef struct {
        bit          side;
        logic [31:0] addr;
        bit          we;
        logic [31:0] wdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0, fails = 0;
    int   ack_mode = 1;
    int   wbeats = 0;
    bit   phase = 1'b0;
    exp_t exp_q[$];
    bit   done_q[$];
    exp_t e;
    bit   ds;

    mem_port_arbiter_if bus ();
    mem_port_arbiter #(.BURST(4), .TIMEOUT(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always_comb bus.m_rdata = bus.m_addr ^ MAGIC;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        fails++;
        $display("FAIL %s: got event expected none", name);
    endtask

    function automatic logic [159:0] outs();
        return {23'd0, bus.i_gnt, bus.i_beat, bus.i_done, bus.d_gnt, bus.d_beat, bus.d_done,
                bus.err, bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata, bus.i_rdata, bus.d_rdata};
    endfunction

    task automatic push_beats(input bit side, input logic [31:0] a0, a1, a2, a3, input bit we);
        logic [31:0] a[4];
        a = '{a0, a1, a2, a3};
        for (int k = 0; k < 4; k++) exp_q.push_back('{side, a[k], we, WBASE + 32'(k)});
    endtask

    task automatic wait_done(input bit side, output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(side ? bus.d_done : bus.i_done) && k < 100);
        if (k >= 100) fail_now(side ? "d_done_wait" : "i_done_wait");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // memory responder and write-data source, driven just after each rising edge
    initial begin
        bus.m_ack = 1'b0;
        bus.d_wdata = WBASE;
        forever begin
            @(posedge clk);
            #1;
            phase = ~phase;
            bus.m_ack = ack_mode == 1 || (ack_mode == 2 && phase);
            bus.d_wdata = WBASE + 32'(wbeats);
        end
    end

    always @(negedge clk)
        if (rst) wbeats = 0;
        else begin
            chk("beat_onehot", bus.i_beat & bus.d_beat, 0);
            if (bus.i_beat | bus.d_beat) begin
                if (exp_q.size() == 0) fail_now("unexpected_beat");
                else begin
                    e = exp_q.pop_front();
                    chk("beat_side", bus.d_beat, e.side);
                    chk("beat_addr", bus.m_addr, e.addr);
                    chk("beat_we", bus.m_we, e.we);
                    if (e.we) chk("beat_wdata", bus.m_wdata, e.wdata);
                    else chk("beat_rdata", e.side ? bus.d_rdata : bus.i_rdata, e.addr ^ MAGIC);
                    if (e.side) chk("i_gnt_during_d", bus.i_gnt, 0);
                end
                if (bus.d_beat) wbeats++;
            end
            if (bus.i_done | bus.d_done) begin
                if (done_q.size() == 0) fail_now("unexpected_done");
                else begin
                    ds = done_q.pop_front();
                    chk("done_side", bus.d_done, ds);
                end
            end
            if (bus.d_done) wbeats = 0;
        end

    initial begin
        int k, nb;
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        bus.d_we = 1'b0;
        bus.i_addr = '0;
        bus.d_addr = '0;
        @(negedge clk);
        chk("reset_outputs", outs(), 0);
        do_reset();
        @(negedge clk);
        chk("idle_outputs", outs(), 0);

        // D refill alone, ack every cycle
        push_beats(1, 32'h100, 32'h104, 32'h108, 32'h10C, 0);
        done_q.push_back(1);
        @(posedge clk);
        #1 bus.d_addr = 32'h104;
        bus.d_req = 1'b1;
        wait_done(1, k);
        chk("d_done_cycle", k, 6);
        chk("d_gnt_in_done", bus.d_gnt, 0);
        bus.d_req = 1'b0;
        repeat (2) @(negedge clk);

        // simultaneous requests after reset: D first, one idle cycle, then I
        do_reset();
        push_beats(1, 32'h30F0, 32'h30F4, 32'h30F8, 32'h30FC, 0);
        push_beats(0, 32'h2000, 32'h2004, 32'h2008, 32'h200C, 0);
        done_q.push_back(1);
        done_q.push_back(0);
        @(posedge clk);
        #1 bus.i_addr = 32'h2008;
        bus.d_addr = 32'h30F0;
        bus.i_req = 1'b1;
        bus.d_req = 1'b1;
        wait_done(1, k);
        bus.d_req = 1'b0;
        @(negedge clk);
        chk("gap_i_gnt", bus.i_gnt, 0);
        chk("gap_m_req", bus.m_req, 0);
        @(negedge clk);
        chk("i_gnt_after_gap", bus.i_gnt, 1);
        chk("i_first_addr", bus.m_addr, 32'h2000);
        wait_done(0, k);
        bus.i_req = 1'b0;
        repeat (2) @(negedge clk);

        // D write-back, ack every other cycle
        push_beats(1, 32'h400, 32'h404, 32'h408, 32'h40C, 1);
        done_q.push_back(1);
        ack_mode = 2;
        @(posedge clk);
        #1 bus.d_addr = 32'h40C;
        bus.d_we = 1'b1;
        bus.d_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("wb_m_we", bus.m_we, 1);
        chk("wb_i_gnt", bus.i_gnt, 0);
        wait_done(1, k);
        bus.d_req = 1'b0;
        bus.d_we = 1'b0;
        ack_mode = 1;
        repeat (2) @(negedge clk);

        // I request dropped after two beats still completes the burst
        push_beats(0, 32'h5000, 32'h5004, 32'h5008, 32'h500C, 0);
        done_q.push_back(0);
        @(posedge clk);
        #1 bus.i_addr = 32'h5004;
        bus.i_req = 1'b1;
        nb = 0;
        k = 0;
        while (nb < 2 && k < 50) begin
            @(negedge clk);
            k++;
            if (bus.i_beat) nb++;
        end
        if (k >= 50) fail_now("i_beat_wait");
        bus.i_req = 1'b0;
        wait_done(0, k);
        repeat (6) @(negedge clk);
        chk("i_idle_after_drop", bus.m_req, 0);

        // timeout with no ack
        ack_mode = 0;
        done_q.push_back(1);
        @(posedge clk);
        @(posedge clk);
        #1 bus.d_addr = 32'h600;
        bus.d_req = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            if (j == 9) begin
                chk("err_before_timeout", bus.err, 0);
                chk("m_req_before_timeout", bus.m_req, 1);
            end
            if (j == 10) begin
                chk("err_at_timeout", bus.err, 1);
                chk("d_done_at_timeout", bus.d_done, 1);
                chk("m_req_at_timeout", bus.m_req, 0);
            end
        end
        bus.d_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("err_sticky", bus.err, 1);
        chk("idle_after_timeout", bus.m_req, 0);

        // reset during beat 2, then restart with D priority
        ack_mode = 1;
        do_reset();
        chk("err_cleared", bus.err, 0);
        push_beats(0, 32'h7000, 32'h7004, 32'h7008, 32'h700C, 0);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        @(posedge clk);
        #1 bus.i_addr = 32'h7000;
        bus.i_req = 1'b1;
        nb = 0;
        k = 0;
        while (nb < 2 && k < 50) begin
            @(negedge clk);
            k++;
            if (bus.i_beat) nb++;
        end
        if (k >= 50) fail_now("i_beat_wait2");
        @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("outputs_in_reset", outs(), 0);
        bus.i_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        push_beats(1, 32'h8000, 32'h8004, 32'h8008, 32'h800C, 0);
        push_beats(0, 32'h7000, 32'h7004, 32'h7008, 32'h700C, 0);
        done_q.push_back(1);
        done_q.push_back(0);
        @(posedge clk);
        #1 bus.d_addr = 32'h8000;
        bus.d_req = 1'b1;
        bus.i_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("restart_d_gnt", bus.d_gnt, 1);
        chk("restart_addr", bus.m_addr, 32'h8000);
        wait_done(1, k);
        bus.d_req = 1'b0;
        wait_done(0, k);
        bus.i_req = 1'b0;
        repeat (3) @(negedge clk);

        chk("beats_left", exp_q.size(), 0);
        chk("dones_left", done_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
